key_schedule: RTL and testbench
===============================

Name: key_schedule

Overview:
- Round-key expansion block that sits directly upstream of the encryption stage pipeline.
- Expands a 256-bit master key into the ten 128-bit round keys K1..K10 defined by GOST R 34.12-2015.
- Runs 32 Feistel iterations over one iterative S/L datapath.
- Holds the keys in a register file that the stage's key_xor reads by stage number.

Parameters:
ITER_NUM, 32, number of Feistel iterations; fixed by the standard, the parameter exists only for the bench.
KEY_NUM, 10, number of round keys stored.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-low reset; rst=0 clears all state immediately
key_i  input  256  master key; [255:128]=K1, [127:0]=K2; sampled only when start_i is accepted
start_i  input  1  start expansion; accepted only in IDLE
busy_o  output  1  high while expansion is in progress
valid_o  output  1  high when K1..K10 are all valid
rkey_idx_i  input  4  round-key index: 1..10 selects K1..K10
rkey_o  output  128  round key selected by rkey_idx_i, registered (1-cycle read latency)

Behaviour:
- Reset values: busy_o=0, valid_o=0, rkey_o=0, all key registers=0, FSM=IDLE.
- Math:
  - S = 8-bit pi substitution per byte.
  - R(a15..a0) = l(a15..a0) || a15..a1, where a15 is byte [127:120].
  - l = 148a15+32a14+133a13+16a12+194a11+192a10+1a9+251a8+1a7+192a6+194a5+16a4+133a3+32a2+148a1+1a0, in GF(2^8) mod 0x1C3.
  - L = R applied 16 times.
  - C_i = L(Vec128(i)).
- Feistel step: (a,b) -> (L(S(a^C_i))^b, a).
- FSM states and transitions:
  - IDLE: start_i=1 -> load a=key_i[255:128], b=key_i[127:0]; write K1, K2; clear valid_o; set busy_o; i=1; go to SUBST.
  - CONST (without CONST_ROM_EN only): 16 R cycles on Vec128(i) into the constant register; then go to SUBST.
  - SUBST (1 cycle): x <= S(a^C_i).
  - LIN (16 cycles): x <= R(x) each cycle.
    - On the 16th cycle: a <= R(x)^b, b <= a.
    - If i%8==0: write K(2i/8+1)=new a and K(2i/8+2)=new b.
    - If i==32: go to IDLE, busy_o=0, valid_o=1.
    - Otherwise: i++ and go to CONST or SUBST.
- Latency with CONST_ROM_EN: valid_o rises 545 cycles after the start cycle (1 load + 32x17).
- Latency without CONST_ROM_EN: valid_o rises 1057 cycles after the start cycle (1 + 32x33).
- Read port:
  - rkey_o <= K[rkey_idx_i] each cycle, regardless of busy_o.
  - Index 0 or 11..15 -> rkey_o <= 0.
  - During expansion, keys not yet rewritten show their old values; consumers must gate on valid_o.
- start_i while busy_o=1: ignored; the key in flight is unaffected.
- start_i in the cycle that valid_o rises: ignored, because the FSM is still finishing.
- rst=0 mid-expansion: all state clears asynchronously; valid_o=0 and keys are zeroed.
- key_i changes after acceptance have no effect.

Optional Feature:
CONST_ROM_EN
- Defined: C_1..C_32 come from a 32x128 constant ROM indexed by i; no CONST state; 17 cycles per iteration.
- Undefined: C_i is computed on the fly in the CONST state by reusing the R engine on Vec128(i); 33 cycles per iteration; no ROM.
- Round keys are bit-identical in both builds.

Test Plan:
1. Reset: hold rst=0 with random inputs -> busy_o=0, valid_o=0, rkey_o=0 for every rkey_idx_i.
2. GOST vector: key_i=8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef, pulse start_i.
   - Response: valid_o rises exactly 545 cycles later (1057 without CONST_ROM_EN).
   - rkey_idx_i=1 -> 8899aabbccddeeff0011223344556677.
   - rkey_idx_i=2 -> fedcba98765432100123456789abcdef.
   - rkey_idx_i=3 -> db31485315694343228d6aef8cc78c44.
   - rkey_idx_i=4 -> 3d4553d8e9cfec6815ebadc40a9ffd04.
   - rkey_idx_i=10 -> 72e9dd7416bcf45b755dbaa88e4a4043.
3. Constant check: internal C_1 == 6ea276726c487ab85d27bd10dd849401 in both builds.
4. Restart abuse: pulse start_i with a different key_i at cycles 5 and 300 of an expansion.
   - Response: both pulses ignored; result equals scenario 2.
   - A new start after valid_o rises clears valid_o next cycle and produces the new key set.
5. Reset mid-operation: drive rst=0 at cycle 200, then release and restart with the GOST key.
   - Response: valid_o=0 and rkey_o=0 during reset.
   - After restart, the scenario 2 values are reproduced.
6. Read port: sweep rkey_idx_i 0..15 after completion.
   - Response: one-cycle latency; 0 for indices 0 and 11..15; K1..K10 otherwise.

Source files
------------

// File: rtl/key_schedule.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : key_schedule                                                  |
// | Purpose  : GOST R 34.12-2015 (Kuznyechik) round-key expansion. Expands a |
// |            256-bit master key into K1..K10 with 32 Feistel iterations on |
// |            one iterative S/L datapath and serves them from a register    |
// |            file with a registered read port. rst is active-low, async.   |
// | Options  : CONST_ROM_EN - iteration constants from a 32x128 ROM (17      |
// |            cycles/iteration); otherwise computed on the fly by the R     |
// |            engine (33 cycles/iteration).                                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module key_schedule #(
   parameter int ITER_NUM = 32,
   parameter int KEY_NUM  = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [255:0] key_i,
   input  logic         start_i,
   output logic         busy_o,
   output logic         valid_o,
   input  logic [3:0]   rkey_idx_i,
   output logic [127:0] rkey_o
);

   // pi substitution table, entry 0 in the most significant byte
   localparam logic [2047:0] PI_TABLE = {
      128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
      128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
      128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
      128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
      128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
      128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
      128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
      128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6};

   // l-function coefficients; byte j multiplies a_j (a15 = byte [127:120])
   localparam logic [127:0] L_COEF = {8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
                                      8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1};

   localparam logic [5:0] LAST_ITER = 6'(ITER_NUM);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CONST = 2'd1,
      ST_SUBST = 2'd2,
      ST_LIN   = 2'd3
   } state_t;

   // GF(2^8) multiply modulo x^8+x^7+x^6+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'hC3 : 8'h00);
      end
      return p;
   endfunction

   // One R step: new top byte is l(a15..a0), remaining bytes shift down by one
   function automatic logic [127:0] r_fn(input logic [127:0] v);
      logic [7:0] l;
      l = '0;
      for (int j = 0; j < 16; j++) l = l ^ gf_mul(v[8*j +: 8], L_COEF[8*j +: 8]);
      return {l, v[127:8]};
   endfunction

   // Bytewise pi substitution
   function automatic logic [127:0] s_fn(input logic [127:0] v);
      logic [127:0] o;
      o = '0;
      for (int j = 0; j < 16; j++) o[8*j +: 8] = PI_TABLE[2040 - 8*int'(v[8*j +: 8]) +: 8];
      return o;
   endfunction

   state_t         state_q, state_d;
   logic [127:0]   a_q, a_d, b_q, b_d, x_q, x_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [5:0]     iter_q, iter_d;
   logic           busy_q, busy_d, valid_q, valid_d;
   logic [127:0]   rkey_q, rkey_d;
   logic [127:0]   key_q [0:KEY_NUM-1];
   logic [127:0]   key_d [0:KEY_NUM-1];
   logic [127:0]   c_cur;
   logic [127:0]   r_in, r_out;

`ifdef CONST_ROM_EN
   // C_i = L(Vec128(i)), folded to constants at elaboration
   function automatic logic [127:0] calc_const(input int idx);
      logic [127:0] v;
      v = 128'(idx);
      for (int k = 0; k < 16; k++) v = r_fn(v);
      return v;
   endfunction

   logic [127:0] c_rom [0:ITER_NUM-1];
   for (genvar k = 0; k < ITER_NUM; k++) begin : g_rom
      localparam logic [127:0] C_VAL = calc_const(k + 1);
      assign c_rom[k] = C_VAL;
   end
   assign c_cur = c_rom[5'(iter_q - 6'd1)];
   assign r_in  = x_q;
`else
   logic [127:0] c_q, c_d;
   assign c_cur = c_q;
   // the single R engine serves constant generation and the L transform
   assign r_in  = (state_q == ST_CONST) ? c_q : x_q;
`endif

   assign r_out = r_fn(r_in);

   // Next-state, datapath and read-port logic
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      x_d     = x_q;
      cnt_d   = cnt_q;
      iter_d  = iter_q;
      busy_d  = busy_q;
      valid_d = valid_q;
      key_d   = key_q;
`ifndef CONST_ROM_EN
      c_d     = c_q;
`endif
      rkey_d  = '0;
      if (rkey_idx_i >= 4'd1 && rkey_idx_i <= 4'(KEY_NUM)) rkey_d = key_q[rkey_idx_i - 4'd1];

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               a_d      = key_i[255:128];
               b_d      = key_i[127:0];
               key_d[0] = key_i[255:128];
               key_d[1] = key_i[127:0];
               valid_d  = 1'b0;
               busy_d   = 1'b1;
               iter_d   = 6'd1;
               cnt_d    = 4'd0;
`ifdef CONST_ROM_EN
               state_d  = ST_SUBST;
`else
               c_d      = 128'd1;
               state_d  = ST_CONST;
`endif
            end
         end
`ifndef CONST_ROM_EN
         ST_CONST: begin
            c_d   = r_out;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) state_d = ST_SUBST;
         end
`endif
         ST_SUBST: begin
            x_d     = s_fn(a_q ^ c_cur);
            cnt_d   = 4'd0;
            state_d = ST_LIN;
         end
         ST_LIN: begin
            x_d   = r_out;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               a_d = r_out ^ b_q;
               b_d = a_q;
               // every eighth iteration yields the next pair of round keys
               if (iter_q[2:0] == 3'd0) begin
                  key_d[iter_q[5:2]]         = r_out ^ b_q;
                  key_d[iter_q[5:2] + 4'd1] = a_q;
               end
               if (iter_q == LAST_ITER) begin
                  busy_d  = 1'b0;
                  valid_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  iter_d  = iter_q + 6'd1;
`ifdef CONST_ROM_EN
                  state_d = ST_SUBST;
`else
                  c_d     = {122'd0, iter_q + 6'd1};
                  state_d = ST_CONST;
`endif
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         x_q     <= '0;
         cnt_q   <= '0;
         iter_q  <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         rkey_q  <= '0;
         for (int k = 0; k < KEY_NUM; k++) key_q[k] <= '0;
`ifndef CONST_ROM_EN
         c_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         x_q     <= x_d;
         cnt_q   <= cnt_d;
         iter_q  <= iter_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         rkey_q  <= rkey_d;
         key_q   <= key_d;
`ifndef CONST_ROM_EN
         c_q     <= c_d;
`endif
      end
   end

   assign busy_o  = busy_q;
   assign valid_o = valid_q;
   assign rkey_o  = rkey_q;

endmodule
`default_nettype wire

// File: tb/tb_key_schedule.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_key_schedule                                               |
// | Purpose  : Self-checking bench for key_schedule (GOST vector, constant,  |
// |            restart abuse, mid-run reset, read-port sweep).               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_key_schedule;

`ifdef CONST_ROM_EN
   localparam int LAT    = 545;
   localparam int C1_CYC = 1;
`else
   localparam int LAT    = 1057;
   localparam int C1_CYC = 17;
`endif
   localparam int LIMIT = 2000;

   localparam logic [255:0] GOST  = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
   localparam logic [255:0] OTHER = 256'h00112233445566778899aabbccddeeff0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   localparam logic [127:0] C1    = 128'h6ea276726c487ab85d27bd10dd849401;
   localparam logic [127:0] SPEC_K3  = 128'hdb31485315694343228d6aef8cc78c44;
   localparam logic [127:0] SPEC_K4  = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
   localparam logic [127:0] SPEC_K10 = 128'h72e9dd7416bcf45b755dbaa88e4a4043;

   localparam int COEF [16] = '{1, 148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148};
   localparam logic [7:0] PI [256] = '{
      8'hFC,8'hEE,8'hDD,8'h11,8'hCF,8'h6E,8'h31,8'h16,8'hFB,8'hC4,8'hFA,8'hDA,8'h23,8'hC5,8'h04,8'h4D,
      8'hE9,8'h77,8'hF0,8'hDB,8'h93,8'h2E,8'h99,8'hBA,8'h17,8'h36,8'hF1,8'hBB,8'h14,8'hCD,8'h5F,8'hC1,
      8'hF9,8'h18,8'h65,8'h5A,8'hE2,8'h5C,8'hEF,8'h21,8'h81,8'h1C,8'h3C,8'h42,8'h8B,8'h01,8'h8E,8'h4F,
      8'h05,8'h84,8'h02,8'hAE,8'hE3,8'h6A,8'h8F,8'hA0,8'h06,8'h0B,8'hED,8'h98,8'h7F,8'hD4,8'hD3,8'h1F,
      8'hEB,8'h34,8'h2C,8'h51,8'hEA,8'hC8,8'h48,8'hAB,8'hF2,8'h2A,8'h68,8'hA2,8'hFD,8'h3A,8'hCE,8'hCC,
      8'hB5,8'h70,8'h0E,8'h56,8'h08,8'h0C,8'h76,8'h12,8'hBF,8'h72,8'h13,8'h47,8'h9C,8'hB7,8'h5D,8'h87,
      8'h15,8'hA1,8'h96,8'h29,8'h10,8'h7B,8'h9A,8'hC7,8'hF3,8'h91,8'h78,8'h6F,8'h9D,8'h9E,8'hB2,8'hB1,
      8'h32,8'h75,8'h19,8'h3D,8'hFF,8'h35,8'h8A,8'h7E,8'h6D,8'h54,8'hC6,8'h80,8'hC3,8'hBD,8'h0D,8'h57,
      8'hDF,8'hF5,8'h24,8'hA9,8'h3E,8'hA8,8'h43,8'hC9,8'hD7,8'h79,8'hD6,8'hF6,8'h7C,8'h22,8'hB9,8'h03,
      8'hE0,8'h0F,8'hEC,8'hDE,8'h7A,8'h94,8'hB0,8'hBC,8'hDC,8'hE8,8'h28,8'h50,8'h4E,8'h33,8'h0A,8'h4A,
      8'hA7,8'h97,8'h60,8'h73,8'h1E,8'h00,8'h62,8'h44,8'h1A,8'hB8,8'h38,8'h82,8'h64,8'h9F,8'h26,8'h41,
      8'hAD,8'h45,8'h46,8'h92,8'h27,8'h5E,8'h55,8'h2F,8'h8C,8'hA3,8'hA5,8'h7D,8'h69,8'hD5,8'h95,8'h3B,
      8'h07,8'h58,8'hB3,8'h40,8'h86,8'hAC,8'h1D,8'hF7,8'h30,8'h37,8'h6B,8'hE4,8'h88,8'hD9,8'hE7,8'h89,
      8'hE1,8'h1B,8'h83,8'h49,8'h4C,8'h3F,8'hF8,8'hFE,8'h8D,8'h53,8'hAA,8'h90,8'hCA,8'hD8,8'h85,8'h61,
      8'h20,8'h71,8'h67,8'hA4,8'h2D,8'h2B,8'h09,8'h5B,8'hCB,8'h9B,8'h25,8'hD0,8'hBE,8'hE5,8'h6C,8'h52,
      8'h59,8'hA6,8'h74,8'hD2,8'hE6,8'hF4,8'hB4,8'hC0,8'hD1,8'h66,8'hAF,8'hC2,8'h39,8'h4B,8'h63,8'hB6};

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] key_i;
   logic         start_i;
   logic         busy_o;
   logic         valid_o;
   logic [3:0]   rkey_idx_i;
   logic [127:0] rkey_o;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [127:0] exp_keys [0:15];
   logic [127:0] exp_q [$];
   logic [3:0]   idx_q [$];
   logic [3:0]   rd_idx [0:31];
   logic [127:0] rd_exp [0:31];
   int           rd_n;

   key_schedule dut (
      .clk        (clk),
      .rst        (rst),
      .key_i      (key_i),
      .start_i    (start_i),
      .busy_o     (busy_o),
      .valid_o    (valid_o),
      .rkey_idx_i (rkey_idx_i),
      .rkey_o     (rkey_o)
   );

   always #5 clk = ~clk;

   // reference model: schoolbook polynomial product then reduction
   function automatic logic [7:0] m_mul(input logic [7:0] x, input logic [7:0] y);
      logic [14:0] p;
      p = '0;
      for (int k = 0; k < 8; k++) if (y[k]) p = p ^ (15'(x) << k);
      for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h1C3 << (k - 8));
      return p[7:0];
   endfunction

   function automatic logic [127:0] m_L(input logic [127:0] v);
      logic [127:0] t;
      logic [7:0]   l;
      t = v;
      for (int r = 0; r < 16; r++) begin
         l = '0;
         for (int j = 0; j < 16; j++) l = l ^ m_mul(t[8*j +: 8], 8'(COEF[j]));
         t = {l, t[127:8]};
      end
      return t;
   endfunction

   function automatic logic [127:0] m_S(input logic [127:0] v);
      logic [127:0] o;
      for (int j = 0; j < 16; j++) o[8*j +: 8] = PI[v[8*j +: 8]];
      return o;
   endfunction

   task automatic compute_model(input logic [255:0] k);
      logic [127:0] a, b, t;
      for (int n = 0; n < 16; n++) exp_keys[n] = '0;
      a = k[255:128];
      b = k[127:0];
      exp_keys[1] = a;
      exp_keys[2] = b;
      for (int i = 1; i <= 32; i++) begin
         t = m_L(m_S(a ^ m_L(128'(i)))) ^ b;
         b = a;
         a = t;
         if (i % 8 == 0) begin
            exp_keys[i/4 + 1] = a;
            exp_keys[i/4 + 2] = b;
         end
      end
   endtask

   task automatic pulse_start(input logic [255:0] k);
      @(negedge clk);
      key_i   = k;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   // counts cycles from the start cycle until valid_o is seen (bounded)
   task automatic wait_valid(inout int cyc);
      while (!valid_o && cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         key_i      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         start_i    = 1'($urandom);
         rkey_idx_i = 4'($urandom);
         #1;
         total_cnt++;
         if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else pass_cnt++;
         total_cnt++;
         if (valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_o); else pass_cnt++;
         total_cnt++;
         if (rkey_o !== 128'd0) $display("FAIL reset_rkey idx=%0d got %h want 0", rkey_idx_i, rkey_o); else pass_cnt++;
      end
      @(negedge clk);
      start_i = 1'b0;
      rst     = 1'b1;
   endtask

   task automatic test_gost_vector;
      int cyc;
      logic [127:0] e;
      logic [3:0]   ix;
      pulse_start(GOST);
      cyc = 1;
      total_cnt++;
      if (busy_o !== 1'b1) $display("FAIL gost_busy got %b want 1", busy_o); else pass_cnt++;
      wait_valid(cyc);
      total_cnt++;
      if (cyc !== LAT) $display("FAIL gost_latency got %0d want %0d", cyc, LAT); else pass_cnt++;
      rd_idx[0] = 4'd1;  rd_exp[0] = GOST[255:128];
      rd_idx[1] = 4'd2;  rd_exp[1] = GOST[127:0];
      rd_idx[2] = 4'd3;  rd_exp[2] = SPEC_K3;
      rd_idx[3] = 4'd4;  rd_exp[3] = SPEC_K4;
      rd_idx[4] = 4'd10; rd_exp[4] = SPEC_K10;
      rd_n = 5;
      for (int n = 0; n <= rd_n; n++) begin
         @(posedge clk); #1;
         if (n < rd_n) begin
            rkey_idx_i = rd_idx[n];
            exp_q.push_back(rd_exp[n]);
            idx_q.push_back(rd_idx[n]);
         end
         #1;
         if (n > 0) begin
            e  = exp_q.pop_front();
            ix = idx_q.pop_front();
            total_cnt++;
            if (rkey_o !== e) $display("FAIL gost_key idx=%0d got %h want %h", ix, rkey_o, e); else pass_cnt++;
         end
      end
   endtask

   task automatic test_const;
      int cyc;
      pulse_start(GOST);
      cyc = 1;
      while (!valid_o && cyc < LIMIT) begin
         if (cyc == C1_CYC) begin
            total_cnt++;
            if (dut.c_cur !== C1) $display("FAIL const_c1 got %h want %h", dut.c_cur, C1); else pass_cnt++;
         end
         @(negedge clk);
         cyc++;
      end
      total_cnt++;
      if (cyc !== LAT) $display("FAIL const_latency got %0d want %0d", cyc, LAT); else pass_cnt++;
   endtask

   task automatic test_restart;
      int cyc;
      logic [127:0] e;
      logic [3:0]   ix;
      pulse_start(GOST);
      cyc   = 1;
      key_i = OTHER;
      while (!valid_o && cyc < LIMIT) begin
         start_i = (cyc == 5 || cyc == 300 || cyc == LAT - 1);
         @(negedge clk);
         cyc++;
      end
      start_i = 1'b0;
      total_cnt++;
      if (cyc !== LAT) $display("FAIL restart_latency got %0d want %0d", cyc, LAT); else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (busy_o !== 1'b0 || valid_o !== 1'b1)
         $display("FAIL restart_at_rise busy=%b valid=%b want busy=0 valid=1", busy_o, valid_o);
      else pass_cnt++;
      for (int pass = 0; pass < 2; pass++) begin
         compute_model(pass == 0 ? GOST : OTHER);
         for (int n = 0; n < 10; n++) begin
            rd_idx[n] = 4'(n + 1);
            rd_exp[n] = exp_keys[n + 1];
         end
         rd_n = 10;
         for (int n = 0; n <= rd_n; n++) begin
            @(posedge clk); #1;
            if (n < rd_n) begin
               rkey_idx_i = rd_idx[n];
               exp_q.push_back(rd_exp[n]);
               idx_q.push_back(rd_idx[n]);
            end
            #1;
            if (n > 0) begin
               e  = exp_q.pop_front();
               ix = idx_q.pop_front();
               total_cnt++;
               if (rkey_o !== e) $display("FAIL restart_key set=%0d idx=%0d got %h want %h", pass, ix, rkey_o, e);
               else pass_cnt++;
            end
         end
         if (pass == 0) begin
            pulse_start(OTHER);
            cyc = 1;
            total_cnt++;
            if (valid_o !== 1'b0 || busy_o !== 1'b1)
               $display("FAIL restart_new_clear valid=%b busy=%b want valid=0 busy=1", valid_o, busy_o);
            else pass_cnt++;
            wait_valid(cyc);
            total_cnt++;
            if (cyc !== LAT) $display("FAIL restart_new_latency got %0d want %0d", cyc, LAT); else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset_mid;
      int cyc;
      logic [127:0] e;
      logic [3:0]   ix;
      pulse_start(GOST);
      cyc = 1;
      while (cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      rst = 1'b0;
      #1;
      total_cnt++;
      if (valid_o !== 1'b0 || busy_o !== 1'b0 || rkey_o !== 128'd0)
         $display("FAIL midreset_clear valid=%b busy=%b rkey=%h want 0/0/0", valid_o, busy_o, rkey_o);
      else pass_cnt++;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      // keys must have been zeroed: K1 and K3 read back as 0
      rd_idx[0] = 4'd1; rd_exp[0] = 128'd0;
      rd_idx[1] = 4'd3; rd_exp[1] = 128'd0;
      rd_n = 2;
      for (int n = 0; n <= rd_n; n++) begin
         @(posedge clk); #1;
         if (n < rd_n) begin
            rkey_idx_i = rd_idx[n];
            exp_q.push_back(rd_exp[n]);
            idx_q.push_back(rd_idx[n]);
         end
         #1;
         if (n > 0) begin
            e  = exp_q.pop_front();
            ix = idx_q.pop_front();
            total_cnt++;
            if (rkey_o !== e) $display("FAIL midreset_zero idx=%0d got %h want %h", ix, rkey_o, e); else pass_cnt++;
         end
      end
      pulse_start(GOST);
      cyc = 1;
      wait_valid(cyc);
      total_cnt++;
      if (cyc !== LAT) $display("FAIL midreset_latency got %0d want %0d", cyc, LAT); else pass_cnt++;
      rd_idx[0] = 4'd3;  rd_exp[0] = SPEC_K3;
      rd_idx[1] = 4'd4;  rd_exp[1] = SPEC_K4;
      rd_idx[2] = 4'd10; rd_exp[2] = SPEC_K10;
      rd_n = 3;
      for (int n = 0; n <= rd_n; n++) begin
         @(posedge clk); #1;
         if (n < rd_n) begin
            rkey_idx_i = rd_idx[n];
            exp_q.push_back(rd_exp[n]);
            idx_q.push_back(rd_idx[n]);
         end
         #1;
         if (n > 0) begin
            e  = exp_q.pop_front();
            ix = idx_q.pop_front();
            total_cnt++;
            if (rkey_o !== e) $display("FAIL midreset_key idx=%0d got %h want %h", ix, rkey_o, e); else pass_cnt++;
         end
      end
   endtask

   task automatic test_read_port;
      logic [127:0] e;
      logic [3:0]   ix;
      compute_model(GOST);
      for (int n = 0; n < 16; n++) begin
         rd_idx[n] = 4'(n);
         rd_exp[n] = exp_keys[n];
      end
      rd_n = 16;
      for (int n = 0; n <= rd_n; n++) begin
         @(posedge clk); #1;
         if (n < rd_n) begin
            rkey_idx_i = rd_idx[n];
            exp_q.push_back(rd_exp[n]);
            idx_q.push_back(rd_idx[n]);
         end
         #1;
         if (n > 0) begin
            e  = exp_q.pop_front();
            ix = idx_q.pop_front();
            total_cnt++;
            if (rkey_o !== e) $display("FAIL read_sweep idx=%0d got %h want %h", ix, rkey_o, e); else pass_cnt++;
         end
      end
   endtask

   initial begin
      rst        = 1'b0;
      key_i      = '0;
      start_i    = 1'b0;
      rkey_idx_i = '0;
      test_reset;
      test_gost_vector;
      test_const;
      test_restart;
      test_reset_mid;
      test_read_port;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
